// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART types and constants (receiver and transmitter).
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Receiver FSM states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        WAIT_HI = 3'd4
    } rx_state_t;

    localparam int   DATA_BITS   = 8;
    localparam logic STOP_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop single-bit synchronizer with selectable reset value.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= RESET_VALUE;
            r_sync <= RESET_VALUE;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver. Synchronizes rx, mid-bit samples each bit,
//               emits a one-clock data_valid or frame_err strobe per frame.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int             HALF_BIT = CLKS_PER_BIT / 2;
    localparam int             CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] c_half_last = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] c_bit_last  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       c_idx_last  = 3'(DATA_BITS - 1);

    logic             w_rx_s;
    rx_state_t        r_state,    w_state_n;
    logic [CNT_W-1:0] r_clk_cnt,  w_clk_cnt_n;
    logic [2:0]       r_bit_idx,  w_bit_idx_n;
    logic [7:0]       r_shift,    w_shift_n;
    logic [7:0]       r_data,     w_data_n;
    logic             r_valid,    w_valid_n;
    logic             r_ferr,     w_ferr_n;

    sync_2ff #(
        .RESET_VALUE (1'b1)
    ) u_rx_sync (
        .clk (clk),
        .rst (rst),
        .i_d (rx),
        .o_q (w_rx_s)
    );

    // State, counters, shift register and output strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_clk_cnt <= w_clk_cnt_n;
            r_bit_idx <= w_bit_idx_n;
            r_shift   <= w_shift_n;
            r_data    <= w_data_n;
            r_valid   <= w_valid_n;
            r_ferr    <= w_ferr_n;
        end
    end

    // Next-state logic; sample points fall on the counter's terminal values
    always_comb begin
        w_state_n   = r_state;
        w_clk_cnt_n = r_clk_cnt;
        w_bit_idx_n = r_bit_idx;
        w_shift_n   = r_shift;
        w_data_n    = r_data;
        w_valid_n   = 1'b0;
        w_ferr_n    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rx_s == START_LEVEL) begin
                    w_state_n   = START;
                    w_clk_cnt_n = '0;
                end
            end
            START: begin
                if (r_clk_cnt == c_half_last) begin
                    w_clk_cnt_n = '0;
                    if (w_rx_s == START_LEVEL) begin
                        w_state_n   = DATA;
                        w_bit_idx_n = '0;
                    end else begin
                        // Too short to be a start bit: treat as a glitch
                        w_state_n = IDLE;
                    end
                end else begin
                    w_clk_cnt_n = r_clk_cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (r_clk_cnt == c_bit_last) begin
                    w_clk_cnt_n = '0;
                    w_shift_n   = {w_rx_s, r_shift[7:1]};
                    if (r_bit_idx == c_idx_last) begin
                        w_state_n = STOP;
                    end else begin
                        w_bit_idx_n = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_clk_cnt_n = r_clk_cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (r_clk_cnt == c_bit_last) begin
                    w_clk_cnt_n = '0;
                    if (w_rx_s == STOP_LEVEL) begin
                        w_data_n  = r_shift;
                        w_valid_n = 1'b1;
                        w_state_n = IDLE;
                    end else begin
                        // Keep the last good byte; wait out a break before rearming
                        w_ferr_n  = 1'b1;
                        w_state_n = WAIT_HI;
                    end
                end else begin
                    w_clk_cnt_n = r_clk_cnt + CNT_W'(1);
                end
            end
            WAIT_HI: begin
                if (w_rx_s == STOP_LEVEL) begin
                    w_state_n = IDLE;
                end
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase
    end

    assign data_out   = r_data;
    assign data_valid = r_valid;
    assign frame_err  = r_ferr;
    assign busy       = (r_state != IDLE);

endmodule : uart_rx
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Self-checking bench for uart_rx (N=11 main DUT, N=15 timing DUT).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int N1 = 11;
    localparam int N2 = 15;
    // rx fall -> data_valid: 2 sync clocks + 1 IDLE decision + HALF_BIT + 9 bit times
    localparam int LAT1 = 3 + (N1 / 2) + 9 * N1;   // 107
    localparam int LAT2 = 3 + (N2 / 2) + 9 * N2;   // 145

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       rx2 = 1'b1;
    logic [7:0] data_out, dout2;
    logic       data_valid, dv2, frame_err, fe2, busy, busy2;

    int checks   = 0;
    int failures = 0;
    int dv_cnt   = 0;
    int fe_cnt   = 0;
    logic [7:0] rx_q[$];

    always #5 clk = ~clk;

    uart_rx #(.CLKS_PER_BIT(N1)) dut (
        .clk(clk), .rst(rst), .rx(rx), .data_out(data_out),
        .data_valid(data_valid), .frame_err(frame_err), .busy(busy)
    );

    uart_rx #(.CLKS_PER_BIT(N2)) dut2 (
        .clk(clk), .rst(rst), .rx(rx2), .data_out(dout2),
        .data_valid(dv2), .frame_err(fe2), .busy(busy2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Strobe monitor on the main DUT, sampled away from the active edge
    always @(negedge clk) begin
        if (data_valid) begin
            rx_q.push_back(data_out);
            dv_cnt++;
        end
        if (frame_err) fe_cnt++;
        if (data_valid && frame_err) begin
            checks++;
            failures++;
            $display("FAIL strobe_overlap: data_valid=1 frame_err=1 expected not both");
        end
    end

    // Drive one 8N1 frame starting at a negedge; which=1 selects the N=15 line
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input bit which);
        logic [9:0] f;
        int nb;
        f  = {stop_bit, d, 1'b0};
        nb = which ? N2 : N1;
        for (int i = 0; i < 10; i++) begin
            if (which) rx2 = f[i]; else rx = f[i];
            repeat (nb) @(negedge clk);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic [7:0] exp_data;
        int         exp_dv;
        int         exp_fe;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int dv0, fe0, lat;
        bit found;

        vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1, 0};
        vecs[1] = '{8'hC3, 1'b1, 8'hC3, 1, 0};
        vecs[2] = '{8'h81, 1'b0, 8'hC3, 0, 1};
        vecs[3] = '{8'h12, 1'b1, 8'h12, 1, 0};
        vecs[4] = '{8'h00, 1'b0, 8'h12, 0, 1};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_data_out", data_out, 0);
        check("reset_valid", data_valid, 0);
        check("reset_ferr", frame_err, 0);
        check("reset_busy", busy, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Table-driven frames with idle gaps
        for (int v = 0; v < 5; v++) begin
            dv0 = dv_cnt; fe0 = fe_cnt;
            send_frame(vecs[v].data, vecs[v].stop, 1'b0);
            rx = 1'b1;
            repeat (6) @(negedge clk);
            check($sformatf("vec%0d_dv_pulses", v), dv_cnt - dv0, vecs[v].exp_dv);
            check($sformatf("vec%0d_fe_pulses", v), fe_cnt - fe0, vecs[v].exp_fe);
            check($sformatf("vec%0d_data_out", v), data_out, vecs[v].exp_data);
            check($sformatf("vec%0d_busy", v), busy, 0);
        end

        // Single frame 0xA5: strobe value, single pulse, busy low afterwards
        fork
            send_frame(8'hA5, 1'b1, 1'b0);
            begin
                found = 0;
                for (int k = 0; k < 200 && !found; k++) begin
                    @(negedge clk);
                    if (data_valid) found = 1;
                end
                check("a5_strobe_seen", found, 1);
                check("a5_data", data_out, 8'hA5);
                check("a5_ferr", frame_err, 0);
                @(negedge clk);
                check("a5_single_pulse", data_valid, 0);
                check("a5_busy_after", busy, 0);
            end
        join
        repeat (4) @(negedge clk);

        // Back-to-back frames without idle gap
        rx_q.delete();
        fe0 = fe_cnt;
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        send_frame(8'h55, 1'b1, 1'b0);
        repeat (6) @(negedge clk);
        check("b2b_count", rx_q.size(), 3);
        if (rx_q.size() == 3) begin
            check("b2b_byte0", rx_q[0], 8'h00);
            check("b2b_byte1", rx_q[1], 8'hFF);
            check("b2b_byte2", rx_q[2], 8'h55);
        end
        check("b2b_no_ferr", fe_cnt - fe0, 0);

        // Short low glitch aborts START at the mid-point
        dv0 = dv_cnt; fe0 = fe_cnt;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        check("glitch_busy_high", busy, 1);
        rx = 1'b1;
        repeat (12) @(negedge clk);
        check("glitch_busy_low", busy, 0);
        check("glitch_no_strobes", (dv_cnt - dv0) + (fe_cnt - fe0), 0);
        send_frame(8'h3C, 1'b1, 1'b0);
        repeat (6) @(negedge clk);
        check("glitch_next_data", data_out, 8'h3C);
        check("glitch_next_dv", dv_cnt - dv0, 1);

        // Bad stop bit followed by a held-low break
        dv0 = dv_cnt; fe0 = fe_cnt;
        send_frame(8'h81, 1'b0, 1'b0);
        repeat (30) @(negedge clk);
        check("break_ferr_pulses", fe_cnt - fe0, 1);
        check("break_no_dv", dv_cnt - dv0, 0);
        check("break_data_kept", data_out, 8'h3C);
        check("break_busy_waiting", busy, 1);
        rx = 1'b1;
        repeat (6) @(negedge clk);
        check("break_busy_released", busy, 0);
        send_frame(8'h7E, 1'b1, 1'b0);
        repeat (6) @(negedge clk);
        check("break_next_data", data_out, 8'h7E);
        check("break_next_dv", dv_cnt - dv0, 1);
        check("break_ferr_total", fe_cnt - fe0, 1);

        // Reset midway through data bit 4 of 0xF0
        dv0 = dv_cnt;
        rx = 1'b0; repeat (N1) @(negedge clk);          // start
        for (int b = 0; b < 4; b++) begin               // bits 0..3 of 0xF0 are 0
            rx = 1'b0; repeat (N1) @(negedge clk);
        end
        rx = 1'b1; repeat (N1 / 2) @(negedge clk);      // half of bit 4
        check("pre_reset_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("rst_async_data", data_out, 0);
        check("rst_async_busy", busy, 0);
        repeat (3) @(negedge clk);
        check("rst_hold_outputs", {data_out, data_valid, frame_err, busy}, 0);
        rst = 1'b0;
        repeat (2 * N1) @(negedge clk);
        check("rst_no_strobe", dv_cnt - dv0, 0);
        send_frame(8'h0F, 1'b1, 1'b0);
        repeat (6) @(negedge clk);
        check("rst_next_data", data_out, 8'h0F);
        check("rst_next_dv", dv_cnt - dv0, 1);

        // Latency from rx falling edge to data_valid, N=11
        fork
            send_frame(8'h5A, 1'b1, 1'b0);
            begin
                lat = 0; found = 0;
                for (int k = 0; k < 400 && !found; k++) begin
                    @(posedge clk); lat++;
                    @(negedge clk);
                    if (data_valid) found = 1;
                end
            end
        join
        check("lat11_seen", found, 1);
        check("lat11_clocks", lat, LAT1);
        check("lat11_data", data_out, 8'h5A);

        // Latency with N=15 (HALF_BIT=7)
        fork
            send_frame(8'hC6, 1'b1, 1'b1);
            begin
                lat = 0; found = 0;
                for (int k = 0; k < 400 && !found; k++) begin
                    @(posedge clk); lat++;
                    @(negedge clk);
                    if (dv2) found = 1;
                end
            end
        join
        check("lat15_seen", found, 1);
        check("lat15_clocks", lat, LAT2);
        check("lat15_data", dout2, 8'hC6);
        check("lat15_no_ferr", fe2, 0);
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_uart_rx
`default_nettype wire
